// File: rtl/comparator_pkg.sv
// Shared constants for the registered magnitude comparator.
// Flag encodings are in {x,y,z} = {gt,eq,lt} order.
package comparator_pkg;

  typedef logic [2:0] cmp_flags_t;

  localparam cmp_flags_t CMP_GT   = 3'b100;
  localparam cmp_flags_t CMP_EQ   = 3'b010;
  localparam cmp_flags_t CMP_LT   = 3'b001;
  localparam cmp_flags_t CMP_NONE = 3'b000;

endpackage : comparator_pkg

// File: rtl/comparator_1bit_dataflow_bit_cell.sv
// One bit slice of the MSB-first magnitude compare chain.
// Once a more significant bit has decided gt or lt, the decision is
// passed through unchanged; otherwise this bit decides (or passes "equal so far").
module cmp_bit_cell (
  input  logic ai,
  input  logic bi,
  input  logic gt_in,
  input  logic lt_in,
  output logic gt_out,
  output logic lt_out
);

  assign gt_out = gt_in | (~lt_in & ai & ~bi);
  assign lt_out = lt_in | (~gt_in & ~ai & bi);

endmodule : cmp_bit_cell

// File: rtl/comparator_1bit_dataflow.sv
// Unsigned magnitude comparator with registered one-hot gt/eq/lt flags.
// Compare is a dataflow chain of cmp_bit_cell slices; only the result is stored.
module comparator_1bit_dataflow
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             out_valid
);

  // Chain index WIDTH is the "nothing decided yet" seed above the MSB.
  logic [WIDTH:0] gt_chain;
  logic [WIDTH:0] lt_chain;
  logic           gt;
  logic           eq;
  logic           lt;

  cmp_flags_t flags_d, flags_q;
  logic       out_valid_d, out_valid_q;

  assign gt_chain[WIDTH] = 1'b0;
  assign lt_chain[WIDTH] = 1'b0;

  generate
    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_chain
      cmp_bit_cell u_cell (
        .ai     (a[i]),
        .bi     (b[i]),
        .gt_in  (gt_chain[i+1]),
        .lt_in  (lt_chain[i+1]),
        .gt_out (gt_chain[i]),
        .lt_out (lt_chain[i])
      );
    end
  endgenerate

  assign gt = gt_chain[0];
  assign lt = lt_chain[0];
  assign eq = ~gt & ~lt;

  // Next-state: capture a fresh result on valid input, otherwise hold flags.
  always_comb begin
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      flags_d     = {gt, eq, lt};
      out_valid_d = 1'b1;
    end
  end

  // Result and valid registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= CMP_NONE;
      out_valid_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign {x, y, z} = flags_q;
  assign out_valid = out_valid_q;

  // Unknown operands must never be sampled.
  a_no_x_operands : assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !$isunknown({a, b}));

endmodule : comparator_1bit_dataflow

// File: tb/tb_comparator_1bit_dataflow.sv
// Bench for comparator_1bit_dataflow: a WIDTH=1 and a WIDTH=4 instance,
// expected flags queued at drive time and popped when the result appears.
module tb_comparator_1bit_dataflow;
  import comparator_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       v1, v4;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic       x1, y1, z1, ov1;
  logic       x4, y4, z4, ov4;

  int unsigned checks;
  int unsigned errors;

  cmp_flags_t q1[$];
  cmp_flags_t q4[$];

  comparator_1bit_dataflow #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .x(x1), .y(y1), .z(z1), .out_valid(ov1)
  );

  comparator_1bit_dataflow #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4),
    .x(x4), .y(y4), .z(z4), .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cmp_flags_t ref_cmp(input int unsigned ra, input int unsigned rb);
    if (ra > rb)       return CMP_GT;
    else if (ra == rb) return CMP_EQ;
    else               return CMP_LT;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    v1 = 1'b0; v4 = 1'b0; a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x1, y1, z1, ov1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_w1 got %b%b%b v=%b want 000 v=0", x1, y1, z1, ov1);
    end
    checks++;
    if ({x4, y4, z4, ov4} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_w4 got %b%b%b v=%b want 000 v=0", x4, y4, z4, ov4);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_w1_basic();
    logic [1:0] pairs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    cmp_flags_t exp;
    foreach (pairs[i]) begin
      @(negedge clk);
      v1 = 1'b1; a1 = pairs[i][1]; b1 = pairs[i][0];
      q1.push_back(ref_cmp(int'(a1), int'(b1)));
      @(posedge clk); #1;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL w1_basic scoreboard empty");
      end else begin
        exp = q1.pop_front();
        if ({x1, y1, z1} !== exp || ov1 !== 1'b1) begin
          errors++;
          $display("FAIL w1_basic[%0d] got %b%b%b v=%b want %b v=1", i, x1, y1, z1, ov1, exp);
        end
      end
    end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    rst_n = 1'b0; v1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x1, y1, z1, ov1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold got %b%b%b v=%b want 000 v=0", x1, y1, z1, ov1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({x1, y1, z1} !== CMP_GT || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got %b%b%b v=%b want %b v=1", x1, y1, z1, ov1, CMP_GT);
    end
  endtask

  task automatic test_hold();
    for (int unsigned n = 0; n < 2; n++) begin
      @(negedge clk);
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({x1, y1, z1} !== CMP_GT || ov1 !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got %b%b%b v=%b want %b v=0", n, x1, y1, z1, ov1, CMP_GT);
      end
    end
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({x1, y1, z1} !== CMP_LT || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL midop_pre got %b%b%b v=%b want %b v=1", x1, y1, z1, ov1, CMP_LT);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({x1, y1, z1, ov1} !== 4'b0000) begin
      errors++;
      $display("FAIL midop_async got %b%b%b v=%b want 000 v=0", x1, y1, z1, ov1);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({x1, y1, z1} !== CMP_LT || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL midop_resume got %b%b%b v=%b want %b v=1", x1, y1, z1, ov1, CMP_LT);
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic test_w4_boundaries();
    logic [3:0] ta [5] = '{4'hF, 4'h0, 4'h8, 4'h6, 4'hA};
    logic [3:0] tb [5] = '{4'h0, 4'hF, 4'h7, 4'h7, 4'hA};
    cmp_flags_t te [5] = '{CMP_GT, CMP_LT, CMP_GT, CMP_LT, CMP_EQ};
    cmp_flags_t exp;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      v4 = 1'b1; a4 = ta[i]; b4 = tb[i];
      q4.push_back(te[i]);
      @(posedge clk); #1;
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL w4_bound scoreboard empty");
      end else begin
        exp = q4.pop_front();
        if ({x4, y4, z4} !== exp || ov4 !== 1'b1) begin
          errors++;
          $display("FAIL w4_bound a=%h b=%h got %b%b%b v=%b want %b v=1",
                   ta[i], tb[i], x4, y4, z4, ov4, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    cmp_flags_t exp;
    for (int unsigned i = 0; i < 256; i++) begin
      @(negedge clk);
      v4 = 1'b1; a4 = 4'(i >> 4); b4 = 4'(i);
      q4.push_back(ref_cmp(i >> 4, i & 32'hF));
      @(posedge clk); #1;
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL b2b scoreboard empty");
      end else begin
        exp = q4.pop_front();
        if ({x4, y4, z4} !== exp || ov4 !== 1'b1) begin
          errors++;
          $display("FAIL b2b a=%h b=%h got %b%b%b v=%b want %b v=1",
                   a4, b4, x4, y4, z4, ov4, exp);
        end
      end
      checks++;
      if (!$onehot({x4, y4, z4})) begin
        errors++;
        $display("FAIL b2b_onehot a=%h b=%h got %b%b%b want one-hot", a4, b4, x4, y4, z4);
      end
    end
    @(negedge clk);
    v4 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_w1_basic();
    test_reset_release();
    test_hold();
    test_midop_reset();
    test_w4_boundaries();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_comparator_1bit_dataflow
